xbus_scheduler: RTL and testbench

Sequencer for the row-bus (X-bus) broadcast network. It accepts transfer commands (target row, target column, data type, length) and drives the `flush`/`Y_TAG` pair that row-bus controllers latch. It then streams the requested number of words from a global-buffer source stream onto the matching G2B data lane, with backpressure from the target PEs. It sits between the global buffer read port and the array of row-bus controllers.

---
 rtl/xbus_pkg.sv | 21 ++
 rtl/xbus_scheduler_if.sv | 51 +++++
 rtl/xbus_scheduler.sv | 120 ++++++++++++
 tb/tb_xbus_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared types for the row-bus (X-bus) broadcast sequencer.
package xbus_pkg;

  // Data type carried by a transfer command.
  typedef enum logic [1:0] {
    DT_IFMAP = 2'd0,
    DT_FLTR  = 2'd1,
    DT_PSUM  = 2'd2,
    DT_RSVD  = 2'd3
  } dtype_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TAG    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/xbus_scheduler_if.sv
// Command, source-stream and G2B bus signals of the X-bus scheduler.
// master: command/data source and PE side; slave: the scheduler.
interface xbus_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int LEN_WIDTH  = 12
);
  localparam int YW = $clog2(NUM_ROW);
  localparam int XW = $clog2(NUM_COL);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [YW-1:0]           cmd_y_tag;
  logic [XW-1:0]           cmd_x_tag;
  logic [1:0]              cmd_type;
  logic [LEN_WIDTH-1:0]    cmd_len;

  logic                    src_valid;
  logic                    src_ready;
  logic [2*DATA_WIDTH-1:0] src_data;

  logic                    bus_ready;
  logic                    flush;
  logic [YW-1:0]           y_tag;
  logic [XW-1:0]           x_tag;
  logic [DATA_WIDTH-1:0]   ifmap_data_G2B;
  logic [DATA_WIDTH-1:0]   fltr_data_G2B;
  logic [2*DATA_WIDTH-1:0] psum_data_G2B;
  logic                    bus_valid;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output cmd_valid, cmd_y_tag, cmd_x_tag, cmd_type, cmd_len,
    output src_valid, src_data, bus_ready,
    input  cmd_ready, src_ready, flush, y_tag, x_tag,
    input  ifmap_data_G2B, fltr_data_G2B, psum_data_G2B,
    input  bus_valid, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_y_tag, cmd_x_tag, cmd_type, cmd_len,
    input  src_valid, src_data, bus_ready,
    output cmd_ready, src_ready, flush, y_tag, x_tag,
    output ifmap_data_G2B, fltr_data_G2B, psum_data_G2B,
    output bus_valid, busy, done, err
  );

endinterface

// File: rtl/xbus_scheduler.sv
// X-bus scheduler: flushes the row tag when the target row changes, then
// streams the requested number of source words onto the G2B lane selected
// by the command data type.
module xbus_scheduler
  import xbus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int LEN_WIDTH  = 12
) (
  input logic             clk,
  input logic             rst,
  xbus_scheduler_if.slave xb
);

  localparam int YW = $clog2(NUM_ROW);
  localparam int XW = $clog2(NUM_COL);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic [YW-1:0]        y_tag_r;
  logic [XW-1:0]        x_tag_r;
  dtype_t               type_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] count;
  logic                 tag_valid;
  logic [YW-1:0]        last_tag;

  logic in_idle;
  logic in_stream;
  logic accept;
  logic beat;
  logic last_beat;

  assign in_idle   = (state == ST_IDLE);
  assign in_stream = (state == ST_STREAM);
  assign accept    = xb.cmd_valid && in_idle;
  assign beat      = in_stream && xb.src_valid && xb.bus_ready;
  // len_r is never 0 in STREAM, so len_r-1 cannot underflow here.
  assign last_beat = beat && (count == (len_r - LEN_ONE));

  assign xb.cmd_ready = in_idle;
  assign xb.busy      = !in_idle;
  assign xb.flush     = (state == ST_TAG);
  assign xb.done      = (state == ST_DONE);
  assign xb.err       = (state == ST_DONE) && (type_r == DT_RSVD);
  assign xb.bus_valid = in_stream && xb.src_valid;
  assign xb.src_ready = in_stream && xb.bus_ready;
  assign xb.y_tag     = y_tag_r;
  assign xb.x_tag     = x_tag_r;

  // Next-state selection; a cached row tag skips the flush/settle pair.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xb.cmd_valid) begin
          if ((xb.cmd_len == '0) || (xb.cmd_type == DT_RSVD))
            state_nxt = ST_DONE;
          else if (tag_valid && (xb.cmd_y_tag == last_tag))
            state_nxt = ST_STREAM;
          else
            state_nxt = ST_TAG;
        end
      end
      ST_TAG:    state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_STREAM;
      ST_STREAM: if (last_beat) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Route the source word onto the lane for the current data type only.
  always_comb begin
    xb.ifmap_data_G2B = '0;
    xb.fltr_data_G2B  = '0;
    xb.psum_data_G2B  = '0;
    if (xb.bus_valid) begin
      case (type_r)
        DT_IFMAP: xb.ifmap_data_G2B = xb.src_data[DATA_WIDTH-1:0];
        DT_FLTR:  xb.fltr_data_G2B  = xb.src_data[DATA_WIDTH-1:0];
        DT_PSUM:  xb.psum_data_G2B  = xb.src_data;
        default:  ;
      endcase
    end
  end

  // State, command capture, beat counter and row-tag cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      y_tag_r   <= '0;
      x_tag_r   <= '0;
      type_r    <= DT_IFMAP;
      len_r     <= '0;
      count     <= '0;
      tag_valid <= 1'b0;
      last_tag  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        y_tag_r <= xb.cmd_y_tag;
        x_tag_r <= xb.cmd_x_tag;
        type_r  <= dtype_t'(xb.cmd_type);
        len_r   <= xb.cmd_len;
        count   <= '0;
      end
      if (state == ST_TAG) begin
        last_tag  <= y_tag_r;
        tag_valid <= 1'b1;
      end
      if (beat)
        count <= last_beat ? '0 : count + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_xbus_scheduler.sv
// Scoreboard bench for xbus_scheduler: stimulus pushes expected flushes,
// beats and completions; a negedge monitor pops and compares them.
module tb_xbus_scheduler;
  localparam int DW = 16, NR = 4, NC = 4, LW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbus_scheduler_if #(.DATA_WIDTH(DW), .NUM_ROW(NR), .NUM_COL(NC), .LEN_WIDTH(LW)) xb();

  xbus_scheduler #(.DATA_WIDTH(DW), .NUM_ROW(NR), .NUM_COL(NC), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .rst(rst),
    .xb (xb.slave)
  );

  typedef struct {
    logic [15:0] ifm;
    logic [15:0] flt;
    logic [31:0] ps;
    logic [1:0]  y;
    logic [1:0]  x;
  } beat_t;

  beat_t       exp_beats[$];
  logic [1:0]  exp_flush[$];
  logic        exp_done[$];
  logic [31:0] src_q[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  int beats_seen = 0, flush_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int last_done_cyc = 0, last_flush_cyc = 0, last_acc_cyc = 0;
  int force_stall = 0;
  bit rand_mode = 0;
  bit hs_s = 0;

  // reference row-tag cache
  bit         m_tag_valid = 0;
  logic [1:0] m_last_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t route(input logic [1:0] t, input logic [31:0] w,
                                  input logic [1:0] y, input logic [1:0] x);
    beat_t b;
    b.ifm = (t == 2'd0) ? w[15:0] : 16'h0;
    b.flt = (t == 2'd1) ? w[15:0] : 16'h0;
    b.ps  = (t == 2'd2) ? w : 32'h0;
    b.y   = y;
    b.x   = x;
    return b;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) hs_s = xb.src_valid & xb.src_ready;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (!xb.bus_valid)
        check("idle_lanes_zero", {xb.ifmap_data_G2B, xb.fltr_data_G2B, xb.psum_data_G2B}, 64'h0);
      check("cmd_ready_vs_busy", xb.cmd_ready, !xb.busy);
      if (!xb.busy) check("src_ready_idle", xb.src_ready, 1'b0);
      if (xb.err) check("err_with_done", xb.done, 1'b1);
      if (xb.cmd_valid && xb.cmd_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (xb.flush) begin
        flush_cnt++;
        last_flush_cyc = cyc;
        check("flush_expected", exp_flush.size() != 0, 1'b1);
        if (exp_flush.size() != 0) check("flush_y_tag", xb.y_tag, exp_flush.pop_front());
      end
      if (xb.bus_valid && xb.src_ready) begin
        beats_seen++;
        check("beat_expected", exp_beats.size() != 0, 1'b1);
        if (exp_beats.size() != 0) begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_lanes", {xb.ifmap_data_G2B, xb.fltr_data_G2B, xb.psum_data_G2B},
                {e.ifm, e.flt, e.ps});
          check("beat_tags", {xb.y_tag, xb.x_tag}, {e.y, e.x});
        end
      end
      if (xb.done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_expected", exp_done.size() != 0, 1'b1);
        if (exp_done.size() != 0) check("done_err", xb.err, exp_done.pop_front());
      end
    end
  end

  // Source / PE-readiness driver
  initial begin
    xb.src_valid = 1'b0;
    xb.src_data  = '0;
    xb.bus_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hs_s && src_q.size() > 0) void'(src_q.pop_front());
      if (force_stall > 0) begin
        xb.bus_ready = 1'b0;
        force_stall--;
      end else begin
        xb.bus_ready = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (src_q.size() == 0) xb.src_valid = 1'b0;
      else if (hs_s || !xb.src_valid) xb.src_valid = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
      xb.src_data = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  // Push the reference expectations for one command, then present it.
  task automatic issue(input logic [1:0] y, input logic [1:0] x, input logic [1:0] t,
                       input int len, input bit use_fixed, input logic [31:0] fixed,
                       input bit hold, output int acc);
    int a0;
    for (int k = 0; k < len; k++) begin
      logic [31:0] w;
      w = use_fixed ? fixed : $urandom;
      src_q.push_back(w);
      exp_beats.push_back(route(t, w, y, x));
    end
    if (len != 0 && t != 2'd3 && !(m_tag_valid && m_last_tag == y)) begin
      exp_flush.push_back(y);
      m_tag_valid = 1;
      m_last_tag  = y;
    end
    exp_done.push_back(t == 2'd3);
    a0 = acc_cnt;
    xb.cmd_y_tag = y;
    xb.cmd_x_tag = x;
    xb.cmd_type  = t;
    xb.cmd_len   = LW'(len);
    xb.cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_cnt == a0; i++) @(posedge clk);
    check("accept_in_time", acc_cnt != a0, 1'b1);
    acc = last_acc_cyc;
    #1;
    if (!hold) xb.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 500 && done_cnt == n0; i++) @(posedge clk);
    check("done_in_time", done_cnt != n0, 1'b1);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {xb.flush, xb.bus_valid, xb.src_ready, xb.done, xb.err, xb.busy}, 6'h0);
    check({tag, "_lanes"}, {xb.ifmap_data_G2B, xb.fltr_data_G2B, xb.psum_data_G2B}, 64'h0);
    check({tag, "_tags"}, {xb.y_tag, xb.x_tag}, 4'h0);
  endtask

  initial begin
    int n, nb, d0, f0, a0, b0, da;
    xb.cmd_valid = 1'b0;
    xb.cmd_y_tag = '0;
    xb.cmd_x_tag = '0;
    xb.cmd_type  = '0;
    xb.cmd_len   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_cmd_ready", xb.cmd_ready, 1'b1);
    @(posedge clk); #1;

    // ifmap miss: flush N+1, beats N+3..N+6, done N+7
    d0 = done_cnt;
    issue(2'd2, 2'd1, 2'd0, 4, 0, 0, 0, n);
    wait_done(d0);
    check("miss_flush_cycle", last_flush_cyc, n + 1);
    check("miss_done_cycle", last_done_cyc, n + 7);

    // ifmap hit on the same row: no flush, done N+3
    d0 = done_cnt; f0 = flush_cnt;
    issue(2'd2, 2'd3, 2'd0, 2, 0, 0, 0, n);
    wait_done(d0);
    check("hit_done_cycle", last_done_cyc, n + 3);
    check("hit_no_flush", flush_cnt, f0);

    // psum with a two-cycle bus stall mid-stream
    d0 = done_cnt; b0 = beats_seen;
    issue(2'd3, 2'd0, 2'd2, 3, 1, 32'hDEAD_BEEF, 0, n);
    for (int i = 0; i < 50 && beats_seen < b0 + 1; i++) @(posedge clk);
    force_stall = 2;
    wait_done(d0);
    check("stall_done_cycle", last_done_cyc, n + 8);
    check("stall_beat_count", beats_seen - b0, 3);

    // zero length and reserved type: done next cycle, no flush
    f0 = flush_cnt; b0 = beats_seen;
    d0 = done_cnt;
    issue(2'd1, 2'd0, 2'd0, 0, 0, 0, 0, n);
    wait_done(d0);
    check("zero_len_done_cycle", last_done_cyc, n + 1);
    d0 = done_cnt;
    issue(2'd1, 2'd2, 2'd3, 5, 0, 0, 0, n);
    wait_done(d0);
    check("rsvd_done_cycle", last_done_cyc, n + 1);
    check("zero_rsvd_no_flush", flush_cnt, f0);
    check("zero_rsvd_no_beats", beats_seen, b0);
    // reserved-type words were never meant to stream
    src_q.delete();
    exp_beats.delete();

    // reset after 2 of 5 beats
    b0 = beats_seen;
    issue(2'd1, 2'd2, 2'd1, 5, 0, 0, 0, n);
    for (int i = 0; i < 100 && beats_seen < b0 + 2; i++) @(posedge clk);
    #2 rst = 1'b1;
    src_q.delete();
    exp_beats.delete();
    exp_done.delete();
    exp_flush.delete();
    m_tag_valid = 0;
    xb.src_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    check("midreset_no_done", done_cnt, d0);
    #1;
    issue(2'd1, 2'd2, 2'd1, 2, 0, 0, 0, n);
    wait_done(d0);
    check("post_reset_flush_cycle", last_flush_cyc, n + 1);
    check("post_reset_done_cycle", last_done_cyc, n + 5);

    // cmd_valid held while busy: second command accepted once, after done
    a0 = acc_cnt; d0 = done_cnt;
    issue(2'd0, 2'd0, 2'd1, 3, 0, 0, 1, n);
    issue(2'd2, 2'd3, 2'd0, 2, 0, 0, 0, nb);
    da = n + 6;
    check("held_first_done", last_done_cyc, da);
    check("held_second_accept", nb, da + 1);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    check("held_accept_count", acc_cnt - a0, 2);
    #1;

    // randomized traffic
    rand_mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] t;
      int len;
      t   = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      len = $urandom_range(6);
      if (t == 2'd3) len = 0;
      issue(2'($urandom_range(3)), 2'($urandom_range(3)), t, len, 0, 0, 0, n);
    end
    for (int i = 0; i < 3000 && exp_done.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("end_done_drained", exp_done.size(), 0);
    check("end_beats_drained", exp_beats.size(), 0);
    check("end_flush_drained", exp_flush.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
